// File: rtl/led_sweep_scheduler.sv
// rtl/led_sweep_scheduler.sv - sweep sequencer for a 9-bit LED updater (optional PAUSE input via LED_SCHED_PAUSE_EN)
module led_sweep_scheduler #(
    parameter int RATE_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              CLOCK_IN,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              ABORT,
`ifdef LED_SCHED_PAUSE_EN
    input  logic              PAUSE,
`endif
    input  logic [CNT_W-1:0]  SWEEP_COUNT,
    input  logic [RATE_W-1:0] RATE_DIV,
    input  logic [8:0]        LED_DATA,
    input  logic              LED_TRIGGER,
    output logic              LED_ENABLE,
    output logic              LED_RESET,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  SWEEPS_DONE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]    sweeps_q, sweeps_d;
    logic                seen_top_q, seen_top_d;
    logic                aborting_q, aborting_d;

    logic                pause_w;
    logic                sweep_end;
    logic                last_sweep;
    logic [CNT_W-1:0]    sweeps_inc;
    logic                led_enable_w;
    logic                led_reset_w;
    logic                done_w;

`ifdef LED_SCHED_PAUSE_EN
    assign pause_w = PAUSE;
`else
    assign pause_w = 1'b0;
`endif

    // A sweep ends when the counter returns to zero after having reached the top
    assign sweeps_inc = sweeps_q + CNT_W'(1);
    assign sweep_end  = seen_top_q && (LED_DATA == 9'd0);
    assign last_sweep = sweep_end && (count_q != '0) && (sweeps_inc == count_q);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rate_q     <= '0;
            tick_q     <= '0;
            sweeps_q   <= '0;
            seen_top_q <= 1'b0;
            aborting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rate_q     <= rate_d;
            tick_q     <= tick_d;
            sweeps_q   <= sweeps_d;
            seen_top_q <= seen_top_d;
            aborting_q <= aborting_d;
        end
    end

    // Next-state and strobe decode; ABORT outranks start and sweep completion
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rate_d       = rate_q;
        tick_d       = tick_q;
        sweeps_d     = sweeps_q;
        seen_top_d   = seen_top_q;
        aborting_d   = aborting_q;
        led_enable_w = 1'b0;
        led_reset_w  = 1'b0;
        done_w       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d    = S_CLEAR;
                    count_d    = SWEEP_COUNT;
                    rate_d     = RATE_DIV;
                    sweeps_d   = '0;
                    aborting_d = 1'b0;
                end
            end
            S_CLEAR: begin
                // aborting_q decides whether this clear leads back to IDLE or into RUN
                led_reset_w = 1'b1;
                seen_top_d  = 1'b0;
                tick_d      = rate_q;
                if (ABORT) begin
                    aborting_d = 1'b1;
                end else if (aborting_q) begin
                    state_d    = S_IDLE;
                    aborting_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d    = S_CLEAR;
                    aborting_d = 1'b1;
                end else begin
                    if (!pause_w) begin
                        tick_d = (tick_q == '0) ? rate_q : tick_q - RATE_W'(1);
                    end
                    if (sweep_end) begin
                        seen_top_d = 1'b0;
                        sweeps_d   = sweeps_inc;
                    end else if (LED_TRIGGER) begin
                        seen_top_d = 1'b1;
                    end
                    if (last_sweep) begin
                        state_d = S_FINISH;
                    end else if (!pause_w && (tick_q == '0)) begin
                        led_enable_w = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                if (ABORT) begin
                    state_d    = S_CLEAR;
                    aborting_d = 1'b1;
                end else begin
                    done_w  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign LED_ENABLE  = led_enable_w;
    assign LED_RESET   = led_reset_w;
    assign DONE        = done_w;
    assign BUSY        = (state_q != S_IDLE);
    assign SWEEPS_DONE = sweeps_q;

endmodule

// File: tb/tb_led_sweep_scheduler.sv
// tb/tb_led_sweep_scheduler.sv - self-checking bench for led_sweep_scheduler
module tb_led_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        pause = 1'b0;
    logic [7:0]  sweep_count;
    logic [15:0] rate_div;
    logic [8:0]  led_data;
    logic        led_trig;
    logic        led_en;
    logic        led_rst;
    logic        busy;
    logic        done;
    logic [7:0]  sweeps;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_sweep_scheduler #(.RATE_W(16), .CNT_W(8)) dut (
        .CLOCK_IN   (clk),
        .RESET_N    (rst_n),
        .START      (start),
        .ABORT      (abort),
`ifdef LED_SCHED_PAUSE_EN
        .PAUSE      (pause),
`endif
        .SWEEP_COUNT(sweep_count),
        .RATE_DIV   (rate_div),
        .LED_DATA   (led_data),
        .LED_TRIGGER(led_trig),
        .LED_ENABLE (led_en),
        .LED_RESET  (led_rst),
        .BUSY       (busy),
        .DONE       (done),
        .SWEEPS_DONE(sweeps)
    );

    // LED updater: triangle counter, holds one step at the top when turning round
    logic [8:0] upd_cnt  = 9'd0;
    logic       upd_down = 1'b0;
    always @(posedge clk) begin
        if (led_rst) begin
            upd_cnt  <= 9'd0;
            upd_down <= 1'b0;
        end else if (led_en) begin
            if (!upd_down) begin
                if (upd_cnt == 9'h1FF) upd_down <= 1'b1;
                else                   upd_cnt  <= upd_cnt + 9'd1;
            end else begin
                upd_cnt <= upd_cnt - 9'd1;
                if (upd_cnt == 9'd1) upd_down <= 1'b0;
            end
        end
    end
    assign led_data = upd_cnt;
    assign led_trig = (upd_cnt == 9'h1FF);

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic longint outs();
        return longint'({led_en, led_rst, busy, done, sweeps});
    endfunction

    // Reference model: phase-level description of the sequencer
    localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_RUN = 2, PH_FINISH = 3;
    int m_ph = PH_IDLE;
    int m_cnt = 0, m_rate = 0, m_sweeps = 0, m_active = 0;
    bit m_seen = 0, m_back = 0;

    // Observation statistics
    bit stats_clr = 0;
    int exp_gap = 1;
    int n_en = 0, n_rst = 0, n_done = 0, gap_err = 0, last_en = -1, cyc_no = 0;

    // Compare process: every falling edge, model expectation vs DUT outputs
    always @(negedge clk) begin : cmp
        bit e_en, e_rst, e_done, e_busy, compl, fin, pz;
        longint e_all;
        cyc_no++;
        if (stats_clr) begin
            n_en = 0; n_rst = 0; n_done = 0; gap_err = 0; last_en = -1;
        end
        if (led_en) begin
            if (last_en >= 0 && (cyc_no - last_en) != exp_gap) gap_err++;
            last_en = cyc_no;
            n_en++;
        end
        if (led_rst) n_rst++;
        if (done) n_done++;
`ifdef LED_SCHED_PAUSE_EN
        pz = pause;
`else
        pz = 1'b0;
`endif
        e_en = 0; e_rst = 0; e_done = 0; e_busy = 0;
        compl = 0; fin = 0;
        if (!rst_n) begin
            m_ph = PH_IDLE; m_cnt = 0; m_rate = 0; m_sweeps = 0;
            m_active = 0; m_seen = 0; m_back = 0;
            chk(outs() == 0, "cycle_outputs_in_reset", outs(), 0);
        end else begin
            e_busy = (m_ph != PH_IDLE);
            if (m_ph == PH_CLEAR) e_rst = 1;
            if (m_ph == PH_FINISH) e_done = !abort;
            if (m_ph == PH_RUN) begin
                compl = m_seen && (led_data == 9'd0);
                fin   = compl && (m_cnt != 0) && (((m_sweeps + 1) % 256) == m_cnt);
                e_en  = !abort && !fin && !pz && ((m_active % (m_rate + 1)) == m_rate);
            end
            e_all = longint'({e_en, e_rst, e_busy, e_done, 8'(m_sweeps)});
            chk(outs() == e_all, "cycle_outputs", outs(), e_all);
            case (m_ph)
                PH_IDLE: if (start && !abort) begin
                    m_ph = PH_CLEAR; m_cnt = int'(sweep_count); m_rate = int'(rate_div);
                    m_sweeps = 0; m_back = 0;
                end
                PH_CLEAR: begin
                    m_seen = 0; m_active = 0;
                    if (abort) m_back = 1;
                    else if (m_back) begin m_ph = PH_IDLE; m_back = 0; end
                    else m_ph = PH_RUN;
                end
                PH_RUN: begin
                    if (abort) begin m_ph = PH_CLEAR; m_back = 1; end
                    else begin
                        if (compl) begin m_sweeps = (m_sweeps + 1) % 256; m_seen = 0; end
                        else if (led_trig) m_seen = 1;
                        if (!pz) m_active++;
                        if (fin) m_ph = PH_FINISH;
                    end
                end
                default: begin
                    if (abort) begin m_ph = PH_CLEAR; m_back = 1; end
                    else m_ph = PH_IDLE;
                end
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        stats_clr = 1; cyc(1); stats_clr = 0;
    endtask

    // Start a sequence, then disturb the inputs to prove they were latched
    task automatic run_seq(input int r, input int c);
        rate_div = 16'(r); sweep_count = 8'(c);
        clear_stats();
        start = 1; cyc(1); start = 0;
        rate_div = 16'd7; sweep_count = 8'd5;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy && k < budget) begin cyc(1); k++; end
        chk(!busy, nm, longint'(busy), 0);
    endtask

    initial begin
        int s;
        rst_n = 0; start = 0; abort = 0; sweep_count = 0; rate_div = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk(outs() == 0, "reset_state", outs(), 0);

        // Single sweep, enable every cycle
        exp_gap = 1;
        run_seq(0, 1);
        wait_idle(3000, "t1_timeout");
        chk(n_en == 1023, "t1_enables", n_en, 1023);
        chk(n_rst == 1, "t1_led_reset_cycles", n_rst, 1);
        chk(n_done == 1, "t1_done_pulses", n_done, 1);
        chk(sweeps == 8'd1, "t1_sweeps_done", sweeps, 1);
        chk(gap_err == 0, "t1_enable_spacing", gap_err, 0);
        cyc(3);
        chk(sweeps == 8'd1 && !busy, "t1_idle_hold", outs(), 1);

        // Two sweeps at RATE_DIV=3, with an ignored START mid-run
        exp_gap = 4;
        run_seq(3, 2);
        cyc(200);
        sweep_count = 8'd1; rate_div = 16'd0;
        start = 1; cyc(1); start = 0;
        wait_idle(10000, "t2_timeout");
        chk(n_en == 2046, "t2_enables", n_en, 2046);
        chk(gap_err == 0, "t2_enable_spacing", gap_err, 0);
        chk(sweeps == 8'd2, "t2_sweeps_done", sweeps, 2);
        chk(n_done == 1, "t2_done_pulses", n_done, 1);
        chk(n_rst == 1, "t2_led_reset_cycles", n_rst, 1);

        // Continuous run aborted after three sweeps
        exp_gap = 1;
        run_seq(0, 0);
        s = 0;
        while (sweeps != 8'd3 && s < 5000) begin cyc(1); s++; end
        chk(sweeps == 8'd3, "t3_reach_three", sweeps, 3);
        cyc(5);
        clear_stats();
        abort = 1; cyc(1); abort = 0;
        wait_idle(20, "t3_timeout");
        chk(n_done == 0, "t3_no_done", n_done, 0);
        chk(n_rst == 1, "t3_abort_reset_cycles", n_rst, 1);
        chk(sweeps == 8'd3, "t3_sweeps_done", sweeps, 3);

        // START and ABORT together in IDLE
        clear_stats();
        sweep_count = 8'd1; rate_div = 16'd0;
        start = 1; abort = 1; cyc(1); start = 0; abort = 0;
        cyc(2);
        chk(busy == 1'b0, "t4_stays_idle", busy, 0);
        chk(n_rst == 0, "t4_no_led_reset", n_rst, 0);

        // Asynchronous reset in the middle of RUN, then a normal sequence
        run_seq(1, 1);
        cyc(50);
        chk(busy == 1'b1, "t5_busy_mid_run", busy, 1);
        @(posedge clk);
        #3 rst_n = 0;
        #1 chk(outs() == 0, "t5_async_reset_outputs", outs(), 0);
        @(posedge clk);
        #1 rst_n = 1;
        run_seq(0, 1);
        wait_idle(3000, "t5_timeout");
        chk(n_en == 1023, "t5_enables", n_en, 1023);
        chk(n_rst == 1, "t5_led_reset_cycles", n_rst, 1);
        chk(n_done == 1, "t5_done_pulses", n_done, 1);
        chk(sweeps == 8'd1, "t5_sweeps_done", sweeps, 1);

`ifdef LED_SCHED_PAUSE_EN
        // Pause for 100 cycles inside RUN
        exp_gap = 3;
        run_seq(2, 1);
        cyc(30);
        s = n_en;
        pause = 1; cyc(100);
        chk(n_en == s, "t6_no_enable_in_pause", n_en - s, 0);
        pause = 0;
        wait_idle(5000, "t6_timeout");
        chk(n_en == 1023, "t6_enables", n_en, 1023);
        chk(n_done == 1, "t6_done_pulses", n_done, 1);
`endif

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sweep_scheduler.md
LED_SWEEP_SCHEDULER -- requirements
Module: led_sweep_scheduler

Interface
REQ-001 SHALL have parameter RATE_W, default 16, width of the enable-rate divider.
REQ-002 SHALL have parameter CNT_W, default 8, width of the sweep-count request and report.
REQ-003 SHALL have port CLOCK_IN  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a sweep sequence.
REQ-006 SHALL have port ABORT  input  1  single-cycle request to cancel the running sequence.
REQ-007 SHALL have port SWEEP_COUNT  input  CNT_W  number of full sweeps to run; 0 means continuous.
REQ-008 SHALL have port RATE_DIV  input  RATE_W  clock cycles between LED enables, minus 1.
REQ-009 SHALL have port LED_DATA  input  9  current count fed back from the LED updater.
REQ-010 SHALL have port LED_TRIGGER  input  1  updater full flag, high when LED_DATA is 9'h1FF.
REQ-011 SHALL have port LED_ENABLE  output  1  single-cycle step strobe to the updater.
REQ-012 SHALL have port LED_RESET  output  1  synchronous, active-high clear to the updater.
REQ-013 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-014 SHALL have port DONE  output  1  single-cycle pulse when a finite sequence completes.
REQ-015 SHALL have port SWEEPS_DONE  output  CNT_W  sweeps completed in the current or last sequence.

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, FINISH; reset state is IDLE.
REQ-017 SHALL move IDLE->CLEAR on START=1 with ABORT=0, latching SWEEP_COUNT and RATE_DIV and zeroing SWEEPS_DONE.
REQ-018 SHALL ignore START in any state other than IDLE; later input changes SHALL NOT affect the latched values.
REQ-019 SHALL assert LED_RESET for exactly the one CLEAR cycle, then go to RUN with the tick counter loaded with latched RATE_DIV.
REQ-020 SHALL, in RUN, decrement the tick counter each cycle and pulse LED_ENABLE when it is 0, reloading latched RATE_DIV in that same cycle.
REQ-021 SHALL emit the first LED_ENABLE in the (RATE_DIV+1)th RUN cycle, so RATE_DIV=0 strobes every RUN cycle.
REQ-022 SHALL set internal flag seen_top when LED_TRIGGER=1 is sampled in RUN; the flag is cleared in CLEAR.
REQ-023 SHALL treat seen_top=1 with LED_DATA=0 as sweep completion: SWEEPS_DONE increments by 1 and seen_top clears in that cycle.
REQ-024 SHALL, on the completion where SWEEPS_DONE+1 equals a nonzero latched SWEEP_COUNT, suppress LED_ENABLE in that cycle and go to FINISH.
REQ-025 SHALL, with SWEEP_COUNT=0, run until ABORT, with SWEEPS_DONE wrapping modulo 2^CNT_W.
REQ-026 SHALL pulse DONE for the one FINISH cycle, then go to IDLE; SWEEPS_DONE holds its value in IDLE.
REQ-027 SHALL, on ABORT in CLEAR, RUN or FINISH, go to CLEAR without DONE, assert LED_RESET, and then return to IDLE.
REQ-028 SHALL give ABORT priority over START and over sweep completion when both fall in the same cycle; ABORT in IDLE has no effect.
REQ-029 SHALL drive LED_ENABLE and LED_RESET low in IDLE and FINISH and never assert both in the same cycle.

Reset
REQ-030 SHALL, on RESET_N=0 and independent of the clock, force IDLE and set LED_ENABLE, LED_RESET, BUSY, DONE, SWEEPS_DONE, seen_top, the tick counter and the latched values to 0.
REQ-031 SHALL, on reset during RUN, drop LED_ENABLE at once; the updater is cleared by the next START's CLEAR cycle.

Configuration
REQ-032 SHALL, with macro LED_SCHED_PAUSE_EN defined, add input PAUSE (1 bit); PAUSE=1 in RUN holds the tick counter and suppresses LED_ENABLE, while ABORT still acts.
REQ-033 SHALL, without LED_SCHED_PAUSE_EN, omit the PAUSE port and behave as if PAUSE=0.

Verification
REQ-034 SHALL cover: RATE_DIV=0, SWEEP_COUNT=1, START -> one LED_RESET cycle, exactly 1023 LED_ENABLE pulses, DONE once, SWEEPS_DONE=1, BUSY low after.
REQ-035 SHALL cover: RATE_DIV=3, SWEEP_COUNT=2 -> enables exactly 4 cycles apart, 2046 enables, SWEEPS_DONE=2, one DONE.
REQ-036 SHALL cover: SWEEP_COUNT=0, ABORT after 3 sweeps -> no DONE, one LED_RESET cycle, then IDLE with SWEEPS_DONE=3.
REQ-037 SHALL cover: START and ABORT in the same IDLE cycle -> stays IDLE, BUSY=0, no LED_RESET; a second START during RUN is ignored.
REQ-038 SHALL cover: RESET_N low mid-RUN between clock edges -> all outputs 0 immediately; a following START runs normally from CLEAR.
REQ-039 SHALL cover: with LED_SCHED_PAUSE_EN, PAUSE high for 100 cycles in RUN -> no LED_ENABLE during the pause, then the enable cadence resumes with the tick counter value it held.
